// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode enum, flag bundle and the legal-opcode test
// used by the arbiter when ALU_ARB_OPCHECK_EN is defined.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_SHL = 4'b0100,
    OP_SHR = 4'b0101,
    OP_AND = 4'b0110,
    OP_OR  = 4'b0111,
    OP_XOR = 4'b1000
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
    logic c;
  } alu_flags_t;

  function automatic logic is_legal_op(input logic [ALU_CTRL_W-1:0] code);
    case (code)
      OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_rsp_buf.sv
// Single-entry response holding register: loaded from the ALU capture,
// emptied on the valid/ready handshake with its client.
module alu_rsp_buf
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_r,
  input  alu_flags_t       load_flags,
  input  logic             load_err,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] r,
  output alu_flags_t       flags,
  output logic             err
);

  // load and consume never coincide: the owner's pending bit blocks a new
  // grant until this entry has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      r     <= '0;
      flags <= '0;
      err   <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      r     <= load_r;
      flags <= load_flags;
      err   <= load_err;
    end else if (valid && ready) begin
      valid <= 1'b0;
      r     <= '0;
      flags <= '0;
      err   <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-client round-robin front end for a shared combinational ALU.
// Optional ALU_ARB_OPCHECK_EN: illegal opcodes issue as 0000 and return err=1.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WIDTH-1:0]  rsp0_r,
  output logic [3:0]        rsp0_flags,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp1_r,
  output logic [3:0]        rsp1_flags,
  output logic              rsp1_err,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_r,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_v,
  input  logic              alu_c
);

  logic [1:0]             req_vld, req_rdy, hs, pend, elig, win;
  logic [1:0]             rsp_vld, rsp_acc, rsp_err, load;
  logic [1:0][WIDTH-1:0]  req_a, req_b, rsp_r;
  logic [1:0][CTRL_W-1:0] req_ctrl;
  alu_flags_t [1:0]       rsp_flg;

  logic                   last, gnt_id, gnt_err;
  logic [CTRL_W-1:0]      gnt_ctrl;
  logic                   iss_v, iss_id, iss_err;
  logic [WIDTH-1:0]       iss_a, iss_b, cap_r;
  logic [CTRL_W-1:0]      iss_ctrl;
  alu_flags_t             cap_flg;

  assign req_vld  = {req1_valid, req0_valid};
  assign req_a    = {req1_a, req0_a};
  assign req_b    = {req1_b, req0_b};
  assign req_ctrl = {req1_ctrl, req0_ctrl};
  assign rsp_acc  = {rsp1_ready, rsp0_ready};

  // Tie goes to whichever client did not win last.
  assign elig   = req_vld & ~pend;
  assign win[0] = elig[0] & (~elig[1] | last);
  assign win[1] = elig[1] & (~elig[0] | ~last);
  assign hs     = req_vld & req_rdy;
  assign gnt_id = hs[1];

`ifdef ALU_ARB_OPCHECK_EN
  assign gnt_err  = ~is_legal_op(req_ctrl[gnt_id]);
  assign gnt_ctrl = gnt_err ? '0 : req_ctrl[gnt_id];
`else
  assign gnt_err  = 1'b0;
  assign gnt_ctrl = req_ctrl[gnt_id];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      last <= 1'b1;
    end else begin
      pend <= (pend | hs) & ~(rsp_vld & rsp_acc);
      if (|hs) last <= gnt_id;
    end
  end

  // Issue stage; operand registers hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_v    <= 1'b0;
      iss_id   <= 1'b0;
      iss_a    <= '0;
      iss_b    <= '0;
      iss_ctrl <= '0;
      iss_err  <= 1'b0;
    end else begin
      iss_v <= |hs;
      if (|hs) begin
        iss_id   <= gnt_id;
        iss_a    <= req_a[gnt_id];
        iss_b    <= req_b[gnt_id];
        iss_ctrl <= gnt_ctrl;
        iss_err  <= gnt_err;
      end
    end
  end

  assign alu_a    = iss_a;
  assign alu_b    = iss_b;
  assign alu_ctrl = iss_ctrl;

  assign cap_r   = iss_err ? '0 : alu_r;
  assign cap_flg = iss_err ? '0 : alu_flags_t'({alu_z, alu_n, alu_v, alu_c});

  for (genvar n = 0; n < 2; n++) begin : g_lane
    assign req_rdy[n] = rst_n & ~pend[n] & (win[n] | ~elig[1-n]);
    assign load[n]    = iss_v & (iss_id == 1'(n));

    alu_rsp_buf #(.WIDTH(WIDTH)) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load[n]),
      .load_r     (cap_r),
      .load_flags (cap_flg),
      .load_err   (iss_err),
      .ready      (rsp_acc[n]),
      .valid      (rsp_vld[n]),
      .r          (rsp_r[n]),
      .flags      (rsp_flg[n]),
      .err        (rsp_err[n])
    );
  end

  assign req0_ready = req_rdy[0];
  assign req1_ready = req_rdy[1];
  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp0_r     = rsp_r[0];
  assign rsp1_r     = rsp_r[1];
  assign rsp0_flags = rsp_flg[0];
  assign rsp1_flags = rsp_flg[1];
  assign rsp0_err   = rsp_err[0];
  assign rsp1_err   = rsp_err[1];

endmodule
